calc_job_scheduler: RTL

CALC_JOB_SCHEDULER -- requirements
Module: calc_job_scheduler

---
 rtl/calc_job_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/calc_job_scheduler.sv
// rtl/calc_job_scheduler.sv - two-requester round-robin front end for a shared leap-year/calculator engine
// One job in flight: grant, issue a start pulse, wait for done or timeout, hold the response until taken.
module calc_job_scheduler #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_year,
  input  logic [7:0]  req0_num1,
  input  logic [7:0]  req0_num2,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_year,
  input  logic [7:0]  req1_num1,
  input  logic [7:0]  req1_num2,
  input  logic [1:0]  req1_op,
  output logic        calc_start,
  output logic [15:0] calc_year,
  output logic [7:0]  calc_num1,
  output logic [7:0]  calc_num2,
  output logic [1:0]  calc_op,
  input  logic        calc_done,
  input  logic        calc_leap,
  input  logic [15:0] calc_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_leap,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [15:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_calc_year;
  logic [7:0]  r_calc_num1;
  logic [7:0]  r_calc_num2;
  logic [1:0]  r_calc_op;
  logic        r_rsp_id;
  logic        r_rsp_leap;
  logic [15:0] r_rsp_result;
  logic        r_rsp_err;
  logic [15:0] r_jobs_done;

  logic w_grant_valid;
  logic w_grant_id;
  logic w_accept;
  logic w_wait_expired;

  // On a tie the requester not served last wins; otherwise whoever is asking.
  always_comb begin
    w_grant_valid = req0_valid | req1_valid;
    w_grant_id    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  end

  assign w_accept       = (r_state == S_IDLE) && w_grant_valid;
  assign w_wait_expired = (r_wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:  w_next_state = w_accept ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  w_next_state = (calc_done || w_wait_expired) ? S_RESP : S_WAIT;
      S_RESP:  w_next_state = rsp_ready ? S_IDLE : S_RESP;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    calc_start = 1'b0;
    rsp_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_grant_valid && !w_grant_id;
        req1_ready = w_grant_valid &&  w_grant_id;
      end
      S_ISSUE: calc_start = 1'b1;
      S_RESP:  rsp_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 8'd0;
      r_calc_year  <= 16'd0;
      r_calc_num1  <= 8'd0;
      r_calc_num2  <= 8'd0;
      r_calc_op    <= 2'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_leap   <= 1'b0;
      r_rsp_result <= 16'd0;
      r_rsp_err    <= 1'b0;
      r_jobs_done  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_id;
        r_rsp_id     <= w_grant_id;
        r_calc_year  <= w_grant_id ? req1_year : req0_year;
        r_calc_num1  <= w_grant_id ? req1_num1 : req0_num1;
        r_calc_num2  <= w_grant_id ? req1_num2 : req0_num2;
        r_calc_op    <= w_grant_id ? req1_op   : req0_op;
      end

      // The counter reads k during the k-th WAIT cycle.
      case (r_state)
        S_ISSUE: r_wait_cnt <= 8'd1;
        S_WAIT:  r_wait_cnt <= (calc_done || w_wait_expired) ? 8'd0 : r_wait_cnt + 8'd1;
        default: r_wait_cnt <= 8'd0;
      endcase

      // Done wins over timeout when both land on the same cycle.
      if (r_state == S_WAIT) begin
        if (calc_done) begin
          r_rsp_leap   <= calc_leap;
          r_rsp_result <= calc_result;
          r_rsp_err    <= 1'b0;
        end else if (w_wait_expired) begin
          r_rsp_leap   <= 1'b0;
          r_rsp_result <= 16'hFFFF;
          r_rsp_err    <= 1'b1;
        end
      end

      if ((r_state == S_RESP) && rsp_ready) begin
        r_jobs_done <= r_jobs_done + 16'd1;
      end
    end
  end

  assign calc_year  = r_calc_year;
  assign calc_num1  = r_calc_num1;
  assign calc_num2  = r_calc_num2;
  assign calc_op    = r_calc_op;
  assign rsp_id     = r_rsp_id;
  assign rsp_leap   = r_rsp_leap;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign jobs_done  = r_jobs_done;

endmodule
